// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: LSL/LSR/ASR/ROR/ROL with carry-out and a sideband tag, registered
// every REG_EVERY mux levels, with valid/ready backpressure through every stage.
module barrel_shifter_pipe #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned REG_EVERY = 1,
    parameter int unsigned TAG_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [2:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_carry,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned LAT = (SHW + REG_EVERY - 1) / REG_EVERY;

    localparam logic [2:0] OpLsl = 3'b000;
    localparam logic [2:0] OpLsr = 3'b001;
    localparam logic [2:0] OpAsr = 3'b010;
    localparam logic [2:0] OpRor = 3'b011;
    localparam logic [2:0] OpRol = 3'b100;

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        localparam int unsigned First = s * REG_EVERY;
        // Shift-amount bits still pending when a beat enters this stage.
        localparam int unsigned AmtW  = SHW - First;
        localparam int unsigned NLvl  = (AmtW < REG_EVERY) ? AmtW : REG_EVERY;

        logic             valid_in;
        logic [WIDTH-1:0] data_in;
        logic             carry_in;
        logic [AmtW-1:0]  amt_in;
        logic [2:0]       op_in;
        logic [TAG_W-1:0] tag_in;
        logic             adv;

        logic             valid_q, valid_d;
        logic [WIDTH-1:0] data_q, data_d;
        logic             carry_q, carry_d;
        logic [TAG_W-1:0] tag_q, tag_d;

        if (s == 0) begin : g_src_port
            assign valid_in = in_valid;
            assign data_in  = in_data;
            assign carry_in = 1'b0;
            assign amt_in   = in_amt;
            assign op_in    = in_op;
            assign tag_in   = in_tag;
        end else begin : g_src_reg
            assign valid_in = g_stage[s-1].valid_q;
            assign data_in  = g_stage[s-1].data_q;
            assign carry_in = g_stage[s-1].carry_q;
            assign amt_in   = g_stage[s-1].g_fwd.amt_q;
            assign op_in    = g_stage[s-1].g_fwd.op_q;
            assign tag_in   = g_stage[s-1].tag_q;
        end

        if (s == LAT - 1) begin : g_adv_last
            assign adv = !valid_q || out_ready;
        end else begin : g_adv_mid
            assign adv = !valid_q || g_stage[s+1].adv;
        end

        // Carry is refreshed at each active level with the last bit that level pushes out;
        // composed over all levels this is the last bit shifted out by the full amount.
        for (genvar j = 0; j < NLvl; j++) begin : g_lvl
            localparam int unsigned Sh = 1 << (First + j);

            logic [WIDTH-1:0] din, dout;
            logic             cin, cout;

            if (j == 0) begin : g_first
                assign din = data_in;
                assign cin = carry_in;
            end else begin : g_next
                assign din = g_lvl[j-1].dout;
                assign cin = g_lvl[j-1].cout;
            end

            always_comb begin
                dout = din;
                cout = cin;
                if (amt_in[j]) begin
                    case (op_in)
                        OpLsl: begin
                            cout = din[WIDTH-Sh];
                            dout = din << Sh;
                        end
                        OpLsr: begin
                            cout = din[Sh-1];
                            dout = din >> Sh;
                        end
                        OpAsr: begin
                            cout = din[Sh-1];
                            dout = $signed(din) >>> Sh;
                        end
                        OpRor: begin
                            cout = din[Sh-1];
                            dout = (din >> Sh) | (din << (WIDTH - Sh));
                        end
                        OpRol: begin
                            cout = din[WIDTH-Sh];
                            dout = (din << Sh) | (din >> (WIDTH - Sh));
                        end
                        default: ;
                    endcase
                end
            end
        end

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            carry_d = carry_q;
            tag_d   = tag_q;
            if (adv) begin
                valid_d = valid_in;
                if (valid_in) begin
                    data_d  = g_lvl[NLvl-1].dout;
                    carry_d = g_lvl[NLvl-1].cout;
                    tag_d   = tag_in;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                carry_q <= 1'b0;
                tag_q   <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
                carry_q <= carry_d;
                tag_q   <= tag_d;
            end
        end

        // Op and the unconsumed amount bits only need to reach the stages that still shift.
        if (s < LAT - 1) begin : g_fwd
            localparam int unsigned FwdW = AmtW - NLvl;

            logic [FwdW-1:0] amt_q, amt_d;
            logic [2:0]      op_q, op_d;

            always_comb begin
                amt_d = amt_q;
                op_d  = op_q;
                if (adv && valid_in) begin
                    amt_d = amt_in[AmtW-1:NLvl];
                    op_d  = op_in;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    amt_q <= '0;
                    op_q  <= '0;
                end else begin
                    amt_q <= amt_d;
                    op_q  <= op_d;
                end
            end
        end
    end

    assign in_ready  = g_stage[0].adv;
    assign out_valid = g_stage[LAT-1].valid_q;
    assign out_data  = g_stage[LAT-1].data_q;
    assign out_carry = g_stage[LAT-1].carry_q;
    assign out_tag   = g_stage[LAT-1].tag_q;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe (WIDTH=32, REG_EVERY=1): directed vectors,
// backpressure, mid-stream reset and a random-bubble stream against a bit-level model.
module tb_barrel_shifter_pipe;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned REG_EVERY = 1;
    localparam int unsigned TAG_W     = 4;
    localparam int unsigned SHW       = 5;
    localparam int unsigned LAT       = (SHW + REG_EVERY - 1) / REG_EVERY;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic [TAG_W-1:0] out_tag;

    barrel_shifter_pipe #(
        .WIDTH     (WIDTH),
        .REG_EVERY (REG_EVERY),
        .TAG_W     (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_tag   (out_tag)
    );

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             carry;
        logic [TAG_W-1:0] tag;
        logic             lat;
        logic [31:0]      cyc;
    } exp_t;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [SHW-1:0]   a;
        logic [2:0]       op;
        logic [WIDTH-1:0] ed;
        logic             ec;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs [18];
    int   errors = 0;
    int   checks = 0;
    int   n_out  = 0;
    int   cyc    = 0;
    bit   rnd_mode = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%h, required 0x%h", name, act, req);
        end
    endtask

    // Bit-by-bit reference: result bit i is picked from its source position in the operand.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] d, input int n,
                                             input logic [2:0] op);
        logic [WIDTH-1:0] r;
        logic             c;
        r = d;
        c = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            case (op)
                3'd0: r[i] = (i >= n) ? d[i-n] : 1'b0;
                3'd1: r[i] = (i + n < WIDTH) ? d[i+n] : 1'b0;
                3'd2: r[i] = (i + n < WIDTH) ? d[i+n] : d[WIDTH-1];
                3'd3: r[i] = d[(i+n)%WIDTH];
                3'd4: r[i] = d[(i-n+WIDTH)%WIDTH];
                default: r[i] = d[i];
            endcase
        end
        if (n != 0) begin
            case (op)
                3'd0:       c = d[WIDTH-n];
                3'd1, 3'd2: c = d[n-1];
                3'd3:       c = r[WIDTH-1];
                3'd4:       c = r[0];
                default:    c = 1'b0;
            endcase
        end
        return {c, r};
    endfunction

    task automatic push(input logic [WIDTH-1:0] d, input logic c, input logic [TAG_W-1:0] t,
                        input logic lat);
        exp_t e;
        e.data  = d;
        e.carry = c;
        e.tag   = t;
        e.lat   = lat;
        e.cyc   = cyc;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic [SHW-1:0] a,
                        input logic [2:0] op, input logic [TAG_W-1:0] t,
                        input logic [WIDTH-1:0] ed, input logic ec, input logic lat);
        int guard;
        bit done;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_op    = op;
        in_tag   = t;
        guard    = 0;
        done     = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                push(ed, ec, t, lat);
                done = 1'b1;
            end else if (guard >= 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0, required 1");
                done = 1'b1;
            end
            guard++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 100) begin
            tick();
            g++;
        end
        chk("queue_empty", WIDTH'(sb.size()), '0);
    endtask

    task automatic load_vec(input int k);
        if (k < 10) begin
            in_data = vecs[k].d;
            in_amt  = vecs[k].a;
            in_op   = vecs[k].op;
            in_tag  = TAG_W'(k);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data 0x%h tag %0d, required no output",
                         out_data, out_tag);
            end else begin
                mon_e = sb.pop_front();
                chk("out_data", out_data, mon_e.data);
                chk("out_carry", WIDTH'(out_carry), WIDTH'(mon_e.carry));
                chk("out_tag", WIDTH'(out_tag), WIDTH'(mon_e.tag));
                if (mon_e.lat) chk("latency", WIDTH'(cyc) - mon_e.cyc, WIDTH'(LAT));
            end
        end
    end

    initial begin
        int acc;
        int n0;
        logic [WIDTH-1:0] rd;
        logic [WIDTH:0]   m;
        int ra;
        int rop;

        vecs[0]  = '{32'hA5A5A5A5, 5'd5,  3'b000, 32'hB4B4B4A0, 1'b0};
        vecs[1]  = '{32'hA5A5A5A5, 5'd5,  3'b001, 32'h052D2D2D, 1'b0};
        vecs[2]  = '{32'hA5A5A5A5, 5'd5,  3'b010, 32'hFD2D2D2D, 1'b0};
        vecs[3]  = '{32'hA5A5A5A5, 5'd5,  3'b011, 32'h2D2D2D2D, 1'b0};
        vecs[4]  = '{32'h00000001, 5'd1,  3'b001, 32'h00000000, 1'b1};
        vecs[5]  = '{32'h80000000, 5'd1,  3'b000, 32'h00000000, 1'b1};
        vecs[6]  = '{32'h12345678, 5'd8,  3'b100, 32'h34567812, 1'b0};
        vecs[7]  = '{32'hDEADBEEF, 5'd0,  3'b010, 32'hDEADBEEF, 1'b0};
        vecs[8]  = '{32'h80000001, 5'd0,  3'b011, 32'h80000001, 1'b0};
        vecs[9]  = '{32'hCAFEF00D, 5'd7,  3'b110, 32'hCAFEF00D, 1'b0};
        vecs[10] = '{32'h0000FFFF, 5'd31, 3'b111, 32'h0000FFFF, 1'b0};
        vecs[11] = '{32'h00000001, 5'd1,  3'b011, 32'h80000000, 1'b1};
        vecs[12] = '{32'h80000000, 5'd31, 3'b010, 32'hFFFFFFFF, 1'b0};
        vecs[13] = '{32'h00000003, 5'd31, 3'b000, 32'h80000000, 1'b1};
        vecs[14] = '{32'h00000002, 5'd31, 3'b100, 32'h00000001, 1'b1};
        vecs[15] = '{32'h12348765, 5'd16, 3'b001, 32'h00001234, 1'b1};
        vecs[16] = '{32'h7FFFFFF0, 5'd4,  3'b010, 32'h07FFFFFF, 1'b0};
        vecs[17] = '{32'h55555555, 5'd3,  3'b101, 32'h55555555, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_out_valid", WIDTH'(out_valid), '0);
        chk("reset_out_data", out_data, '0);
        chk("reset_out_carry", WIDTH'(out_carry), '0);
        chk("reset_out_tag", WIDTH'(out_tag), '0);
        chk("reset_in_ready", WIDTH'(in_ready), WIDTH'(1));

        // Back-to-back directed vectors, unstalled, with latency checked per beat.
        for (int i = 0; i < 18; i++) begin
            send(vecs[i].d, vecs[i].a, vecs[i].op, TAG_W'(i), vecs[i].ed, vecs[i].ec, 1'b1);
        end
        drain();

        // Full backpressure: exactly LAT beats fit, outputs hold, then a 1/cycle drain.
        out_ready = 1'b0;
        acc       = 0;
        in_valid  = 1'b1;
        load_vec(acc);
        repeat (12) begin
            @(negedge clk);
            if (in_ready && acc < 10) begin
                push(vecs[acc].ed, vecs[acc].ec, TAG_W'(acc), 1'b0);
                acc++;
            end
            tick();
            load_vec(acc);
        end
        chk("accepted_while_stalled", WIDTH'(acc), WIDTH'(LAT));
        repeat (3) begin
            @(negedge clk);
            chk("stall_out_valid", WIDTH'(out_valid), WIDTH'(1));
            chk("stall_in_ready", WIDTH'(in_ready), '0);
            if (sb.size() != 0) begin
                chk("stall_out_data", out_data, sb[0].data);
                chk("stall_out_tag", WIDTH'(out_tag), WIDTH'(sb[0].tag));
            end
            tick();
        end
        out_ready = 1'b1;
        n0 = n_out;
        for (int k = acc; k < 10; k++) begin
            send(vecs[k].d, vecs[k].a, vecs[k].op, TAG_W'(k), vecs[k].ed, vecs[k].ec, 1'b0);
        end
        repeat (5) tick();
        chk("release_beats_out", WIDTH'(n_out - n0), WIDTH'(10));
        drain();

        // Reset with three beats in flight: they must vanish without trace.
        for (int k = 0; k < 3; k++) begin
            send(vecs[k].d, vecs[k].a, vecs[k].op, TAG_W'(k), vecs[k].ed, vecs[k].ec, 1'b0);
        end
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        chk("midreset_out_valid", WIDTH'(out_valid), '0);
        chk("midreset_in_ready", WIDTH'(in_ready), WIDTH'(1));
        repeat (8) tick();
        send(vecs[6].d, vecs[6].a, vecs[6].op, 4'hA, vecs[6].ed, vecs[6].ec, 1'b1);
        drain();

        // Random ops and amounts with input bubbles and random output stalls.
        rnd_mode = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 2) == 0) tick();
            rd  = $urandom;
            ra  = $urandom_range(0, WIDTH - 1);
            rop = $urandom_range(0, 7);
            m   = model(rd, ra, 3'(rop));
            send(rd, SHW'(ra), 3'(rop), TAG_W'(k), m[WIDTH-1:0], m[WIDTH], 1'b0);
        end
        rnd_mode  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
